// File: rtl/ptp_int_svc.sv
// PTP interrupt service initiator: programs the interrupt mask, reads and clears status, and dispatches per-source service requests.
// Optional per-source event counters are built when PTP_INT_SVC_CNT_EN is defined.
module ptp_int_svc #(
    parameter logic [31:0] INT_BASE_ADDR = 32'h300,
    parameter int          ACK_TIMEOUT   = 1024,
    parameter int          GUARD_CYCLES  = 4,
    parameter int          CNT_W         = 16
) (
    input  logic             bus2ip_clk,
    input  logic             bus2ip_rst,
    input  logic             int_ptp_i,
    output logic [31:0]      bus2ip_addr_o,
    output logic [31:0]      bus2ip_data_o,
    output logic             bus2ip_rd_ce_o,
    output logic             bus2ip_wr_ce_o,
    input  logic [31:0]      ip2bus_data_i,
    input  logic [2:0]       mask_i,
    input  logic             mask_upd_i,
    output logic [2:0]       svc_req_o,
    input  logic [2:0]       svc_ack_i,
    output logic             busy_o,
    output logic             spurious_o,
    output logic             timeout_o,
    output logic [CNT_W-1:0] cnt_xms_o,
    output logic [CNT_W-1:0] cnt_rx_o,
    output logic [CNT_W-1:0] cnt_tx_o
);

    typedef enum logic [2:0] {
        ST_MASK_WR  = 3'd0,
        ST_IDLE     = 3'd1,
        ST_RD_STAT  = 3'd2,
        ST_EVAL     = 3'd3,
        ST_WAIT_ACK = 3'd4,
        ST_GUARD    = 3'd5
    } state_t;

    localparam logic [15:0] ACK_LAST   = 16'(ACK_TIMEOUT - 1);
    localparam logic [15:0] GUARD_LAST = 16'(GUARD_CYCLES - 1);

    state_t      state_r;
    state_t      next_state_s;
    logic [15:0] timer_r;
    logic [2:0]  status_r;
    logic        pend_r;
    logic [2:0]  pend_mask_r;
    logic [2:0]  svc_req_r;
    logic [2:0]  rem_s;
    logic [2:0]  mask_sel_s;
    logic [31:0] addr_nxt_s;
    logic [31:0] data_nxt_s;
    logic        rd_nxt_s;
    logic        wr_nxt_s;
    logic [31:0] addr_r;
    logic [31:0] data_r;
    logic        rd_ce_r;
    logic        wr_ce_r;
    logic        busy_r;
    logic        spurious_r;
    logic        timeout_r;
    logic [28:0] unused_data_s;

    assign unused_data_s = ip2bus_data_i[31:3];
    assign rem_s         = svc_req_r & ~svc_ack_i;
    assign mask_sel_s    = pend_r ? pend_mask_r : mask_i;

    // State register
    always_ff @(posedge bus2ip_clk) begin
        if (bus2ip_rst) begin
            state_r <= ST_MASK_WR;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic; MASK_WR holds until its write strobe has actually been driven
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_MASK_WR: begin
                if (wr_ce_r) next_state_s = ST_GUARD;
                else         next_state_s = ST_MASK_WR;
            end
            ST_IDLE: begin
                if (pend_r)         next_state_s = ST_MASK_WR;
                else if (int_ptp_i) next_state_s = ST_RD_STAT;
                else                next_state_s = ST_IDLE;
            end
            ST_RD_STAT: next_state_s = ST_EVAL;
            ST_EVAL: begin
                if (status_r == 3'b000) next_state_s = ST_GUARD;
                else                    next_state_s = ST_WAIT_ACK;
            end
            ST_WAIT_ACK: begin
                if (rem_s == 3'b000)         next_state_s = ST_GUARD;
                else if (timer_r == ACK_LAST) next_state_s = ST_GUARD;
                else                         next_state_s = ST_WAIT_ACK;
            end
            ST_GUARD: begin
                if (timer_r == GUARD_LAST) next_state_s = ST_IDLE;
                else                       next_state_s = ST_GUARD;
            end
            default: next_state_s = ST_MASK_WR;
        endcase
    end

    // Bus outputs are decoded from the next state so the strobe coincides with the state
    always_comb begin
        addr_nxt_s = 32'd0;
        data_nxt_s = 32'd0;
        rd_nxt_s   = 1'b0;
        wr_nxt_s   = 1'b0;
        case (next_state_s)
            ST_MASK_WR: begin
                wr_nxt_s   = 1'b1;
                addr_nxt_s = INT_BASE_ADDR + 32'd1;
                data_nxt_s = {29'd0, mask_sel_s};
            end
            ST_RD_STAT: begin
                rd_nxt_s   = 1'b1;
                addr_nxt_s = INT_BASE_ADDR;
            end
            default: begin
                rd_nxt_s = 1'b0;
            end
        endcase
    end

    // Shared timer: ack wait and guard interval, restarted on every state change
    always_ff @(posedge bus2ip_clk) begin
        if (bus2ip_rst) begin
            timer_r <= 16'd0;
        end else if ((next_state_s != state_r) ||
                     ((state_r != ST_WAIT_ACK) && (state_r != ST_GUARD))) begin
            timer_r <= 16'd0;
        end else begin
            timer_r <= timer_r + 16'd1;
        end
    end

    // Status capture, pending mask and service requests
    always_ff @(posedge bus2ip_clk) begin
        if (bus2ip_rst) begin
            status_r    <= 3'b000;
            pend_r      <= 1'b0;
            pend_mask_r <= 3'b000;
            svc_req_r   <= 3'b000;
        end else begin
            if (state_r == ST_RD_STAT) status_r <= ip2bus_data_i[2:0];
            else                       status_r <= status_r;

            if (mask_upd_i && (state_r != ST_MASK_WR)) begin
                pend_r      <= 1'b1;
                pend_mask_r <= mask_i;
            end else if (next_state_s == ST_MASK_WR) begin
                pend_r      <= 1'b0;
                pend_mask_r <= pend_mask_r;
            end else begin
                pend_r      <= pend_r;
                pend_mask_r <= pend_mask_r;
            end

            case (state_r)
                ST_EVAL:     svc_req_r <= (next_state_s == ST_WAIT_ACK) ? status_r : 3'b000;
                ST_WAIT_ACK: svc_req_r <= (next_state_s == ST_WAIT_ACK) ? rem_s : 3'b000;
                default:     svc_req_r <= 3'b000;
            endcase
        end
    end

    // Registered bus, status and pulse outputs
    always_ff @(posedge bus2ip_clk) begin
        if (bus2ip_rst) begin
            addr_r     <= 32'd0;
            data_r     <= 32'd0;
            rd_ce_r    <= 1'b0;
            wr_ce_r    <= 1'b0;
            busy_r     <= 1'b0;
            spurious_r <= 1'b0;
            timeout_r  <= 1'b0;
        end else begin
            addr_r     <= addr_nxt_s;
            data_r     <= data_nxt_s;
            rd_ce_r    <= rd_nxt_s;
            wr_ce_r    <= wr_nxt_s;
            busy_r     <= (next_state_s != ST_IDLE);
            spurious_r <= (state_r == ST_EVAL) && (status_r == 3'b000);
            timeout_r  <= (state_r == ST_WAIT_ACK) && (rem_s != 3'b000) && (timer_r == ACK_LAST);
        end
    end

    assign bus2ip_addr_o  = addr_r;
    assign bus2ip_data_o  = data_r;
    assign bus2ip_rd_ce_o = rd_ce_r;
    assign bus2ip_wr_ce_o = wr_ce_r;
    assign svc_req_o      = svc_req_r;
    assign busy_o         = busy_r;
    assign spurious_o     = spurious_r;
    assign timeout_o      = timeout_r;

`ifdef PTP_INT_SVC_CNT_EN
    logic [CNT_W-1:0] cnt_xms_r;
    logic [CNT_W-1:0] cnt_rx_r;
    logic [CNT_W-1:0] cnt_tx_r;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
        if (en && (v != {CNT_W{1'b1}})) sat_inc = v + {{(CNT_W-1){1'b0}}, 1'b1};
        else                             sat_inc = v;
    endfunction

    // Event counters advance once per evaluated status read
    always_ff @(posedge bus2ip_clk) begin
        if (bus2ip_rst) begin
            cnt_xms_r <= {CNT_W{1'b0}};
            cnt_rx_r  <= {CNT_W{1'b0}};
            cnt_tx_r  <= {CNT_W{1'b0}};
        end else begin
            cnt_xms_r <= sat_inc(cnt_xms_r, (state_r == ST_EVAL) && status_r[2]);
            cnt_rx_r  <= sat_inc(cnt_rx_r,  (state_r == ST_EVAL) && status_r[1]);
            cnt_tx_r  <= sat_inc(cnt_tx_r,  (state_r == ST_EVAL) && status_r[0]);
        end
    end

    assign cnt_xms_o = cnt_xms_r;
    assign cnt_rx_o  = cnt_rx_r;
    assign cnt_tx_o  = cnt_tx_r;
`else
    assign cnt_xms_o = {CNT_W{1'b0}};
    assign cnt_rx_o  = {CNT_W{1'b0}};
    assign cnt_tx_o  = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_ptp_int_svc.sv
// Directed self-checking bench for ptp_int_svc (ACK_TIMEOUT=16, GUARD_CYCLES=4).
module tb_ptp_int_svc;

    logic        bus2ip_clk;
    logic        bus2ip_rst;
    logic        int_ptp_i;
    logic [31:0] bus2ip_addr_o;
    logic [31:0] bus2ip_data_o;
    logic        bus2ip_rd_ce_o;
    logic        bus2ip_wr_ce_o;
    logic [31:0] ip2bus_data_i;
    logic [2:0]  mask_i;
    logic        mask_upd_i;
    logic [2:0]  svc_req_o;
    logic [2:0]  svc_ack_i;
    logic        busy_o;
    logic        spurious_o;
    logic        timeout_o;
    logic [15:0] cnt_xms_o;
    logic [15:0] cnt_rx_o;
    logic [15:0] cnt_tx_o;

    int checks;
    int failures;

    ptp_int_svc #(
        .INT_BASE_ADDR(32'h300),
        .ACK_TIMEOUT  (16),
        .GUARD_CYCLES (4),
        .CNT_W        (16)
    ) dut (
        .bus2ip_clk    (bus2ip_clk),
        .bus2ip_rst    (bus2ip_rst),
        .int_ptp_i     (int_ptp_i),
        .bus2ip_addr_o (bus2ip_addr_o),
        .bus2ip_data_o (bus2ip_data_o),
        .bus2ip_rd_ce_o(bus2ip_rd_ce_o),
        .bus2ip_wr_ce_o(bus2ip_wr_ce_o),
        .ip2bus_data_i (ip2bus_data_i),
        .mask_i        (mask_i),
        .mask_upd_i    (mask_upd_i),
        .svc_req_o     (svc_req_o),
        .svc_ack_i     (svc_ack_i),
        .busy_o        (busy_o),
        .spurious_o    (spurious_o),
        .timeout_o     (timeout_o),
        .cnt_xms_o     (cnt_xms_o),
        .cnt_rx_o      (cnt_rx_o),
        .cnt_tx_o      (cnt_tx_o)
    );

    initial bus2ip_clk = 1'b0;
    always #5 bus2ip_clk = ~bus2ip_clk;

    task automatic cyc(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge bus2ip_clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        checks        = 0;
        failures      = 0;
        bus2ip_rst    = 1'b1;
        int_ptp_i     = 1'b0;
        ip2bus_data_i = 32'h0;
        mask_i        = 3'b101;
        mask_upd_i    = 1'b0;
        svc_ack_i     = 3'b000;

        // Reset values
        cyc(2);
        chk("rst_wr_ce", {31'd0, bus2ip_wr_ce_o}, 32'd0);
        chk("rst_rd_ce", {31'd0, bus2ip_rd_ce_o}, 32'd0);
        chk("rst_addr", bus2ip_addr_o, 32'd0);
        chk("rst_data", bus2ip_data_o, 32'd0);
        chk("rst_busy", {31'd0, busy_o}, 32'd0);
        chk("rst_svc", {29'd0, svc_req_o}, 32'd0);

        // Initial mask write after release
        bus2ip_rst = 1'b0;
        cyc(1);
        chk("init_wr_ce", {31'd0, bus2ip_wr_ce_o}, 32'd1);
        chk("init_addr", bus2ip_addr_o, 32'h301);
        chk("init_data", bus2ip_data_o, 32'h5);
        chk("init_busy", {31'd0, busy_o}, 32'd1);
        cyc(1);
        chk("init_wr_one_cycle", {31'd0, bus2ip_wr_ce_o}, 32'd0);
        chk("guard_busy_1", {31'd0, busy_o}, 32'd1);
        cyc(3);
        chk("guard_busy_4", {31'd0, busy_o}, 32'd1);
        cyc(1);
        chk("idle_busy", {31'd0, busy_o}, 32'd0);

        // Status 0x6: rd, then requests, staggered acks
        int_ptp_i     = 1'b1;
        ip2bus_data_i = 32'hFFFF_FFF6;
        cyc(1);
        chk("s6_rd_ce", {31'd0, bus2ip_rd_ce_o}, 32'd1);
        chk("s6_rd_addr", bus2ip_addr_o, 32'h300);
        int_ptp_i = 1'b0;
        cyc(1);
        chk("s6_rd_one_cycle", {31'd0, bus2ip_rd_ce_o}, 32'd0);
        chk("s6_eval_svc", {29'd0, svc_req_o}, 32'd0);
        cyc(1);
        chk("s6_svc_rise", {29'd0, svc_req_o}, 32'h6);
        svc_ack_i = 3'b011;
        cyc(1);
        chk("s6_ack1_drop", {29'd0, svc_req_o}, 32'h4);
        svc_ack_i = 3'b000;
        cyc(2);
        chk("s6_hold_bit2", {29'd0, svc_req_o}, 32'h4);
        svc_ack_i = 3'b100;
        cyc(1);
        chk("s6_ack2_drop", {29'd0, svc_req_o}, 32'h0);
        chk("s6_no_timeout", {31'd0, timeout_o}, 32'd0);
        chk("s6_guard_busy", {31'd0, busy_o}, 32'd1);
        svc_ack_i = 3'b000;
        cyc(4);
        chk("s6_idle", {31'd0, busy_o}, 32'd0);

        // Spurious read
        int_ptp_i     = 1'b1;
        ip2bus_data_i = 32'hFFFF_FFF8;
        cyc(1);
        chk("sp_rd_ce", {31'd0, bus2ip_rd_ce_o}, 32'd1);
        int_ptp_i = 1'b0;
        cyc(2);
        chk("sp_pulse", {31'd0, spurious_o}, 32'd1);
        chk("sp_svc", {29'd0, svc_req_o}, 32'd0);
        cyc(1);
        chk("sp_pulse_end", {31'd0, spurious_o}, 32'd0);
        cyc(3);
        chk("sp_idle", {31'd0, busy_o}, 32'd0);

        // Ack timeout
        int_ptp_i     = 1'b1;
        ip2bus_data_i = 32'h1;
        cyc(1);
        int_ptp_i = 1'b0;
        cyc(2);
        chk("to_svc_rise", {29'd0, svc_req_o}, 32'h1);
        cyc(15);
        chk("to_svc_hold", {29'd0, svc_req_o}, 32'h1);
        chk("to_not_yet", {31'd0, timeout_o}, 32'd0);
        cyc(1);
        chk("to_svc_drop", {29'd0, svc_req_o}, 32'h0);
        chk("to_pulse", {31'd0, timeout_o}, 32'd1);
        cyc(1);
        chk("to_pulse_end", {31'd0, timeout_o}, 32'd0);
        cyc(3);
        chk("to_idle", {31'd0, busy_o}, 32'd0);

        // Final ack on the timeout cycle wins
        int_ptp_i = 1'b1;
        cyc(1);
        int_ptp_i = 1'b0;
        cyc(2);
        chk("ta_svc_rise", {29'd0, svc_req_o}, 32'h1);
        cyc(15);
        svc_ack_i = 3'b001;
        cyc(1);
        chk("ta_svc_drop", {29'd0, svc_req_o}, 32'h0);
        chk("ta_no_timeout", {31'd0, timeout_o}, 32'd0);
        svc_ack_i = 3'b000;
        cyc(1);
        chk("ta_no_timeout_late", {31'd0, timeout_o}, 32'd0);
        cyc(3);
        chk("ta_idle", {31'd0, busy_o}, 32'd0);

        // Mask update during WAIT_ACK takes priority over a held interrupt
        int_ptp_i = 1'b1;
        cyc(1);
        chk("mu_rd_ce", {31'd0, bus2ip_rd_ce_o}, 32'd1);
        cyc(2);
        chk("mu_svc_rise", {29'd0, svc_req_o}, 32'h1);
        mask_i     = 3'b010;
        mask_upd_i = 1'b1;
        cyc(1);
        mask_upd_i = 1'b0;
        mask_i     = 3'b111;
        svc_ack_i  = 3'b001;
        cyc(1);
        chk("mu_svc_drop", {29'd0, svc_req_o}, 32'h0);
        svc_ack_i = 3'b000;
        cyc(4);
        chk("mu_idle_no_rd", {31'd0, bus2ip_rd_ce_o}, 32'd0);
        cyc(1);
        chk("mu_wr_ce", {31'd0, bus2ip_wr_ce_o}, 32'd1);
        chk("mu_rd_ce_low", {31'd0, bus2ip_rd_ce_o}, 32'd0);
        chk("mu_wr_addr", bus2ip_addr_o, 32'h301);
        chk("mu_wr_data", bus2ip_data_o, 32'h2);
        cyc(5);
        chk("mu_idle_after_wr", {31'd0, bus2ip_rd_ce_o}, 32'd0);
        cyc(1);
        chk("mu_rd_after_wr", {31'd0, bus2ip_rd_ce_o}, 32'd1);
        chk("mu_rd_addr", bus2ip_addr_o, 32'h300);
        int_ptp_i = 1'b0;
        cyc(2);
        chk("mu_svc_again", {29'd0, svc_req_o}, 32'h1);

`ifdef PTP_INT_SVC_CNT_EN
        chk("cnt_tx", {16'd0, cnt_tx_o}, 32'd4);
        chk("cnt_rx", {16'd0, cnt_rx_o}, 32'd1);
        chk("cnt_xms", {16'd0, cnt_xms_o}, 32'd1);
`else
        chk("cnt_tx_off", {16'd0, cnt_tx_o}, 32'd0);
        chk("cnt_rx_off", {16'd0, cnt_rx_o}, 32'd0);
        chk("cnt_xms_off", {16'd0, cnt_xms_o}, 32'd0);
`endif

        // Reset mid WAIT_ACK
        bus2ip_rst = 1'b1;
        cyc(1);
        chk("mr_svc", {29'd0, svc_req_o}, 32'd0);
        chk("mr_busy", {31'd0, busy_o}, 32'd0);
        chk("mr_wr_ce", {31'd0, bus2ip_wr_ce_o}, 32'd0);
        chk("mr_addr", bus2ip_addr_o, 32'd0);
        chk("mr_cnt_tx", {16'd0, cnt_tx_o}, 32'd0);
        bus2ip_rst = 1'b0;
        mask_i     = 3'b011;
        cyc(1);
        chk("mr_wr_after", {31'd0, bus2ip_wr_ce_o}, 32'd1);
        chk("mr_wr_addr", bus2ip_addr_o, 32'h301);
        chk("mr_wr_data", bus2ip_data_o, 32'h3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
